// File: rtl/deal_controller_if.sv
// Shuffler load channel and player/dealer card-request channel of the deal controller.
// master = controller side, slave = shuffler plus the two card consumers.
interface deal_controller_if;
  logic       shuf_req;
  logic [5:0] shuf_seed;
  logic       load_valid;
  logic [5:0] load_card;
  logic       req_player;
  logic       req_dealer;
  logic       gnt_player;
  logic       gnt_dealer;
  logic [5:0] card_out;

  modport master (
    output shuf_req, shuf_seed, gnt_player, gnt_dealer, card_out,
    input  load_valid, load_card, req_player, req_dealer
  );

  modport slave (
    input  shuf_req, shuf_seed, gnt_player, gnt_dealer, card_out,
    output load_valid, load_card, req_player, req_dealer
  );
endinterface

// File: rtl/deal_controller.sv
// Shuffle sequencing, deck capture and round-robin dealing; grant one cycle after request, requests stall outside READY.
// Optional DEAL_STATS_EN adds per-consumer grant counters and a completed-shuffle counter.
module deal_controller #(
  parameter int DECK_SIZE     = 52,
  parameter int RESHUF_THRESH = 15,
  parameter int SHUF_TIMEOUT  = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        new_round,
  input  logic [5:0]  seed_in,
  deal_controller_if.master bus,
  output logic [5:0]  remaining,
  output logic        ready,
  output logic        err_timeout
`ifdef DEAL_STATS_EN
  ,
  output logic [5:0]  stat_player,
  output logic [5:0]  stat_dealer,
  output logic [7:0]  stat_shuffles
`endif
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_SHUFFLE = 2'd1;
  localparam logic [1:0] S_LOAD    = 2'd2;
  localparam logic [1:0] S_READY   = 2'd3;

  logic [1:0]  state;
  logic [5:0]  wr_ptr;
  logic [5:0]  rd_ptr;
  logic [5:0]  rem_q;
  logic [5:0]  seed_q;
  logic [5:0]  card_q;
  logic [11:0] tcnt;
  logic        shuf_req_q;
  logic        gnt_p_q;
  logic        gnt_d_q;
  logic        rr_last;     // 1: dealer was granted last
  logic        err_q;
  logic [5:0]  deck [DECK_SIZE];

  logic        in_load;
  logic        card_ok;
  logic        strobe_ok;
  logic        load_done;
  logic        timed_out;
  logic        elig_p;
  logic        elig_d;
  logic        can_deal;
  logic        grant_p;
  logic        grant_d;
  logic        do_grant;
  logic [5:0]  rem_after;
  logic        enter_shuf;

  // A requester still sees its own grant cycle with req high; that is not a new request.
  assign elig_p    = bus.req_player & ~gnt_p_q;
  assign elig_d    = bus.req_dealer & ~gnt_d_q;
  assign can_deal  = (state == S_READY) && (rem_q != 6'd0);
  assign grant_p   = can_deal & elig_p & (~elig_d | rr_last);
  assign grant_d   = can_deal & elig_d & (~elig_p | ~rr_last);
  assign do_grant  = grant_p | grant_d;
  assign rem_after = rem_q - {5'd0, do_grant};

  assign in_load   = (state == S_SHUFFLE) || (state == S_LOAD);
  assign card_ok   = bus.load_card < 6'(DECK_SIZE);
  assign strobe_ok = in_load & bus.load_valid & card_ok;
  assign load_done = strobe_ok && (wr_ptr == 6'(DECK_SIZE - 1));
  assign timed_out = in_load && !load_done && (tcnt == 12'(SHUF_TIMEOUT - 1));

  // Threshold test sees the post-grant count, so a same-cycle grant completes first.
  assign enter_shuf = ((state == S_IDLE) && start) ||
                      ((state == S_READY) &&
                       ((rem_after == 6'd0) || (new_round && (rem_after < 6'(RESHUF_THRESH)))));

  always_ff @(posedge clk) begin
    if (strobe_ok)
      deck[wr_ptr] <= bus.load_card;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      wr_ptr     <= 6'd0;
      rd_ptr     <= 6'd0;
      rem_q      <= 6'd0;
      seed_q     <= 6'd0;
      card_q     <= 6'd0;
      tcnt       <= 12'd0;
      shuf_req_q <= 1'b0;
      gnt_p_q    <= 1'b0;
      gnt_d_q    <= 1'b0;
      rr_last    <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      gnt_p_q <= grant_p;
      gnt_d_q <= grant_d;
      if (do_grant) begin
        card_q  <= deck[rd_ptr];
        rd_ptr  <= rd_ptr + 6'd1;
        rem_q   <= rem_after;
        rr_last <= grant_d;
      end

      if (enter_shuf) begin
        state      <= S_SHUFFLE;
        seed_q     <= (seed_in == 6'd0) ? 6'd1 : seed_in;
        wr_ptr     <= 6'd0;
        rd_ptr     <= 6'd0;
        rem_q      <= 6'd0;
        tcnt       <= 12'd0;
        shuf_req_q <= 1'b1;
        if (state == S_IDLE)
          err_q <= 1'b0;
      end else if (in_load) begin
        if (load_done) begin
          state      <= S_READY;
          wr_ptr     <= wr_ptr + 6'd1;
          rem_q      <= 6'(DECK_SIZE);
          shuf_req_q <= 1'b0;
        end else if (timed_out) begin
          state      <= S_IDLE;
          err_q      <= 1'b1;
          shuf_req_q <= 1'b0;
        end else begin
          tcnt <= tcnt + 12'd1;
          if (strobe_ok)
            wr_ptr <= wr_ptr + 6'd1;
          if ((state == S_SHUFFLE) && bus.load_valid)
            state <= S_LOAD;
        end
      end
    end
  end

`ifdef DEAL_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_player   <= 6'd0;
      stat_dealer   <= 6'd0;
      stat_shuffles <= 8'd0;
    end else begin
      if (enter_shuf) begin
        stat_player <= 6'd0;
        stat_dealer <= 6'd0;
      end else begin
        if (grant_p && (stat_player != 6'h3F))
          stat_player <= stat_player + 6'd1;
        if (grant_d && (stat_dealer != 6'h3F))
          stat_dealer <= stat_dealer + 6'd1;
      end
      if (load_done)
        stat_shuffles <= stat_shuffles + 8'd1;
    end
  end
`endif

  assign bus.shuf_req   = shuf_req_q;
  assign bus.shuf_seed  = seed_q;
  assign bus.gnt_player = gnt_p_q;
  assign bus.gnt_dealer = gnt_d_q;
  assign bus.card_out   = card_q;
  assign remaining      = rem_q;
  assign ready          = (state == S_READY);
  assign err_timeout    = err_q;

endmodule

// File: tb/tb_deal_controller.sv
// Randomized bench for deal_controller: a scoreboard queue holds the cards the shuffler model loaded,
// in deck order; a monitor pops one per grant and checks card_out and remaining.
module tb_deal_controller;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       new_round = 1'b0;
  logic [5:0] seed_in = 6'd0;
  logic [5:0] remaining;
  logic       ready;
  logic       err_timeout;
`ifdef DEAL_STATS_EN
  logic [5:0] stat_player;
  logic [5:0] stat_dealer;
  logic [7:0] stat_shuffles;
`endif

  deal_controller_if bus ();

  deal_controller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .new_round   (new_round),
    .seed_in     (seed_in),
    .bus         (bus),
    .remaining   (remaining),
    .ready       (ready),
    .err_timeout (err_timeout)
`ifdef DEAL_STATS_EN
    ,
    .stat_player   (stat_player),
    .stat_dealer   (stat_dealer),
    .stat_shuffles (stat_shuffles)
`endif
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [5:0] exp_q[$];     // cards still in the deck, front = next to deal
  bit         model_last = 1'b1;  // 1: dealer granted last

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every grant must deal the next loaded card.
  logic [5:0] mon_card;
  always @(negedge clk) begin
    if (rst_n && (bus.gnt_player || bus.gnt_dealer)) begin
      chk("single_grant", {31'd0, bus.gnt_player & bus.gnt_dealer}, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_grant card=%0d expected=no_grant", bus.card_out);
      end else begin
        mon_card = exp_q.pop_front();
        chk("card_out", bus.card_out, mon_card);
        chk("remaining_after_grant", remaining, exp_q.size());
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_shuf_req"}, bus.shuf_req, 0);
    chk({tag, "_shuf_seed"}, bus.shuf_seed, 0);
    chk({tag, "_gnt"}, {bus.gnt_player, bus.gnt_dealer}, 0);
    chk({tag, "_card_out"}, bus.card_out, 0);
    chk({tag, "_remaining"}, remaining, 0);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_err"}, err_timeout, 0);
  endtask

  // Shuffler model: random permutation, random gaps, optional out-of-range card before index bad_at.
  task automatic load_deck(input int ncards, input int bad_at, output logic [5:0] first);
    int perm[52];
    int j, tmp;
    for (int i = 0; i < 52; i++) perm[i] = i;
    for (int i = 51; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
    end
    first = 6'(perm[0]);
    for (int i = 0; i < ncards; i++) begin
      if (i == bad_at) begin
        bus.load_valid = 1'b1; bus.load_card = 6'd60;
        @(negedge clk);
        bus.load_valid = 1'b0;
      end
      repeat ($urandom_range(2, 0)) @(negedge clk);
      exp_q.push_back(6'(perm[i]));
      bus.load_valid = 1'b1; bus.load_card = 6'(perm[i]);
      @(negedge clk);
      bus.load_valid = 1'b0;
      bus.load_card = 6'($urandom_range(63, 0));
      if (bad_at >= 0 && bad_at <= 50 && i == 50) begin
        chk("ready_after_52_strobes_with_bad", ready, 0);
        chk("remaining_after_52_strobes_with_bad", remaining, 0);
      end
    end
  endtask

  // Deal n cards with random single or paired requests; winner order from the round-robin rule.
  task automatic deal_n(input int n);
    bit order[$];
    bit both, who;
    int waitc;
    while (n > 0) begin
      order.delete();
      both = (n >= 2) && ($urandom_range(1, 0) == 1);
      if (both) begin
        order.push_back(~model_last);
        order.push_back(model_last);
        bus.req_player = 1'b1; bus.req_dealer = 1'b1;
      end else begin
        who = 1'($urandom_range(1, 0));
        order.push_back(who);
        if (who) bus.req_dealer = 1'b1; else bus.req_player = 1'b1;
      end
      model_last = order[order.size() - 1];
      waitc = 0;
      while (order.size() > 0 && waitc < 50) begin
        @(negedge clk);
        waitc++;
        if (bus.gnt_player || bus.gnt_dealer) begin
          chk("grant_winner", bus.gnt_dealer, order.pop_front());
          if (bus.gnt_player) bus.req_player = 1'b0;
          if (bus.gnt_dealer) bus.req_dealer = 1'b0;
          n--;
        end
      end
      if (order.size() > 0) begin
        checks++; errors++;
        $display("FAIL deal_wait granted=none expected=%0d more grants", order.size());
        bus.req_player = 1'b0; bus.req_dealer = 1'b0;
        n = 0;
      end
    end
  endtask

  task automatic pulse_start(input logic [5:0] seed);
    seed_in = seed; start = 1'b1;
    @(negedge clk);
    start = 1'b0; seed_in = 6'($urandom_range(63, 1));
  endtask

  initial begin
    logic [5:0] first;
    int k, cnt;
    bus.load_valid = 1'b0; bus.load_card = 6'd0;
    bus.req_player = 1'b0; bus.req_dealer = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // First shuffle and full load
    pulse_start(6'h2B);
    chk("t1_shuf_req", bus.shuf_req, 1);
    chk("t1_shuf_seed", bus.shuf_seed, 6'h2B);
    chk("t1_ready_loading", ready, 0);
    load_deck(52, -1, first);
    chk("t1_ready", ready, 1);
    chk("t1_remaining", remaining, 52);
    chk("t1_shuf_req_low", bus.shuf_req, 0);

    // Both held: grants alternate P,D,P,D starting with the player
    bus.req_player = 1'b1; bus.req_dealer = 1'b1;
    k = 0; cnt = 0;
    while (k < 4 && cnt < 40) begin
      @(negedge clk);
      cnt++;
      if (bus.gnt_player || bus.gnt_dealer) begin
        chk("t2_alternate", bus.gnt_dealer, k % 2);
        k++;
        if (k == 4) begin bus.req_player = 1'b0; bus.req_dealer = 1'b0; end
      end
    end
    bus.req_player = 1'b0; bus.req_dealer = 1'b0;
    model_last = 1'b1;
    chk("t2_grant_count", k, 4);
    @(negedge clk);
    chk("t2_remaining", remaining, 48);

    // Threshold boundary: 15 left keeps dealing, 14 left reshuffles
    deal_n(33);
    chk("t3_remaining15", remaining, 15);
    new_round = 1'b1; @(negedge clk); new_round = 1'b0;
    chk("t3_no_reshuffle_at_15", ready, 1);
    chk("t3_no_shuf_req_at_15", bus.shuf_req, 0);
    deal_n(1);
    new_round = 1'b1; seed_in = 6'h15; @(negedge clk); new_round = 1'b0;
    exp_q.delete();
    chk("t3_shuf_req", bus.shuf_req, 1);
    chk("t3_ready_low", ready, 0);
    chk("t3_seed", bus.shuf_seed, 6'h15);
    bus.req_dealer = 1'b1;
    repeat (4) @(negedge clk);
    chk("t3_stalled", bus.gnt_dealer, 0);
    load_deck(52, -1, first);
    cnt = 0;
    while (!bus.gnt_dealer && cnt < 10) begin @(negedge clk); cnt++; end
    chk("t3_pending_served", bus.gnt_dealer, 1);
    chk("t3_first_card", bus.card_out, first);
    bus.req_dealer = 1'b0;
    model_last = 1'b1;

    // Reset in the middle of a load
    deal_n(37);
    new_round = 1'b1; @(negedge clk); new_round = 1'b0;
    exp_q.delete();
    load_deck(20, -1, first);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_midload_reset");
    exp_q.delete();
    model_last = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Zero seed substitution and an out-of-range card needing 53 strobes
    pulse_start(6'd0);
    chk("t4_seed_zero", bus.shuf_seed, 1);
    chk("t4_shuf_req", bus.shuf_req, 1);
    load_deck(52, 26, first);
    chk("t4_ready", ready, 1);
    chk("t4_remaining", remaining, 52);

    // Drain the deck: auto reshuffle, then let the shuffle time out
    deal_n(52);
    chk("t5_auto_shuf_req", bus.shuf_req, 1);
    chk("t5_auto_ready_low", ready, 0);
    cnt = 0;
    while (!err_timeout && cnt < 5000) begin @(negedge clk); cnt++; end
    chk("t5_err_timeout", err_timeout, 1);
    checks++;
    if (cnt < 4094 || cnt > 4096) begin
      errors++;
      $display("FAIL t5_timeout_cycles actual=%0d expected=4095", cnt);
    end
    chk("t5_shuf_req_dropped", bus.shuf_req, 0);
    chk("t5_ready_idle", ready, 0);
    pulse_start(6'h3F);
    chk("t5_err_cleared", err_timeout, 0);
    chk("t5_restart_seed", bus.shuf_seed, 6'h3F);
    load_deck(52, -1, first);
    deal_n(10);
    @(negedge clk);
    chk("final_remaining", remaining, 42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog time_limit reached");
    $fatal(1);
  end

endmodule
